// File: rtl/caesar_ciphertext_collector.sv
// caesar_ciphertext_collector
//
// Downstream stage of the Caesar cipher core. Each valid ciphertext
// character is buffered in a first-word-fall-through FIFO. The FIFO is
// drained on a valid/ready byte stream. The block also keeps saturating
// statistics and a sticky overflow flag.
//
// Parameters:
//   DEPTH  FIFO depth in characters (power of two, >= 2)
//   CNT_W  width of each statistics counter
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   ciphertext_char            character from the cipher core
//   flag_ciphertext_ready      qualifier for ciphertext_char (push request)
//   err_invalid_key_shift_num  core key-error flag, counted per cycle
//   err_invalid_ptxt_char      core plaintext-error flag, counted per cycle
//   clear_stats                clears counters and overflow on the next edge
//   out_char, out_valid        head of FIFO (00 when empty), FIFO not empty
//   out_ready                  consumer accepts out_char with out_valid
//   fifo_count                 current occupancy, 0..DEPTH
//   overflow                   sticky: a character was dropped on a full FIFO
//   char_count                 characters written into the FIFO
//   key_err_count              cycles with the key-error flag high
//   ptxt_err_count             cycles with the plaintext-error flag high
module caesar_ciphertext_collector #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 ciphertext_char,
    input  logic                       flag_ciphertext_ready,
    input  logic                       err_invalid_key_shift_num,
    input  logic                       err_invalid_ptxt_char,
    input  logic                       clear_stats,
    output logic [7:0]                 out_char,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           char_count,
    output logic [CNT_W-1:0]           key_err_count,
    output logic [CNT_W-1:0]           ptxt_err_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    assign push  = flag_ciphertext_ready;
    assign full  = (fifo_count == FULL_COUNT);
    assign pop   = out_valid && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign out_valid = (fifo_count != '0);
    assign out_char  = out_valid ? mem[rd_ptr] : 8'h00;

    // Storage has no reset; the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= ciphertext_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !wr_en) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Statistics: clear_stats beats any simultaneous increment or drop.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            overflow       <= 1'b0;
            char_count     <= '0;
            key_err_count  <= '0;
            ptxt_err_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (wr_en && (char_count != '1)) begin
                char_count <= char_count + 1'b1;
            end
            if (err_invalid_key_shift_num && (key_err_count != '1)) begin
                key_err_count <= key_err_count + 1'b1;
            end
            if (err_invalid_ptxt_char && (ptxt_err_count != '1)) begin
                ptxt_err_count <= ptxt_err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_caesar_ciphertext_collector.sv
// Directed self-checking bench for caesar_ciphertext_collector.
// Two instances share all inputs: the default build (DEPTH=16, CNT_W=16) and
// a CNT_W=4 build that is used to observe counter saturation.
module tb_caesar_ciphertext_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ciphertext_char;
    logic        flag_ciphertext_ready;
    logic        err_invalid_key_shift_num;
    logic        err_invalid_ptxt_char;
    logic        clear_stats;
    logic        out_ready;

    logic [7:0]  out_char;
    logic        out_valid;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] char_count;
    logic [15:0] key_err_count;
    logic [15:0] ptxt_err_count;

    logic [7:0]  s_out_char;
    logic        s_out_valid;
    logic [4:0]  s_fifo_count;
    logic        s_overflow;
    logic [3:0]  s_char_count;
    logic [3:0]  s_key_err_count;
    logic [3:0]  s_ptxt_err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    caesar_ciphertext_collector #(.DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ciphertext_char(ciphertext_char),
        .flag_ciphertext_ready(flag_ciphertext_ready),
        .err_invalid_key_shift_num(err_invalid_key_shift_num),
        .err_invalid_ptxt_char(err_invalid_ptxt_char),
        .clear_stats(clear_stats),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow),
        .char_count(char_count), .key_err_count(key_err_count),
        .ptxt_err_count(ptxt_err_count)
    );

    caesar_ciphertext_collector #(.DEPTH(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .ciphertext_char(ciphertext_char),
        .flag_ciphertext_ready(flag_ciphertext_ready),
        .err_invalid_key_shift_num(err_invalid_key_shift_num),
        .err_invalid_ptxt_char(err_invalid_ptxt_char),
        .clear_stats(clear_stats),
        .out_char(s_out_char), .out_valid(s_out_valid), .out_ready(out_ready),
        .fifo_count(s_fifo_count), .overflow(s_overflow),
        .char_count(s_char_count), .key_err_count(s_key_err_count),
        .ptxt_err_count(s_ptxt_err_count)
    );

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ciphertext_char = 8'h00; flag_ciphertext_ready = 1'b0;
        err_invalid_key_shift_num = 1'b0; err_invalid_ptxt_char = 1'b0;
        clear_stats = 1'b0; out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_char !== 8'h00) begin bad++; $display("FAIL reset_char got=%h exp=00", out_char); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if ({char_count, key_err_count, ptxt_err_count} !== 48'd0) begin bad++;
            $display("FAIL reset_counters got=%h/%h/%h exp=0", char_count, key_err_count, ptxt_err_count); end
    endtask

    task automatic test_basic_stream();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43;
        out_ready = 1'b0;
        flag_ciphertext_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ciphertext_char = exp_seq[i];
            tick();
            // first character is visible one cycle after it was sampled
            if (i == 0) begin
                total++; if (out_valid !== 1'b1 || out_char !== 8'h41) begin bad++;
                    $display("FAIL basic_latency got=%b/%h exp=1/41", out_valid, out_char); end
            end
        end
        flag_ciphertext_ready = 1'b0;
        total++; if (fifo_count !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", fifo_count); end
        total++; if (char_count !== 16'd3) begin bad++; $display("FAIL basic_chars got=%0d exp=3", char_count); end
        tick();
        total++; if (out_char !== 8'h41) begin bad++; $display("FAIL basic_hold got=%h exp=41", out_char); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || out_char !== exp_seq[i]) begin bad++;
                $display("FAIL basic_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_char, exp_seq[i]); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || out_char !== 8'h00) begin bad++;
            $display("FAIL basic_empty got=%b/%h exp=0/00", out_valid, out_char); end
    endtask

    task automatic test_overflow();
        pulse_clear();
        out_ready = 1'b0;
        flag_ciphertext_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ciphertext_char = 8'h60 + 8'(i);
            tick();
            if (i == 15) begin
                total++; if (overflow !== 1'b0 || fifo_count !== 5'd16) begin bad++;
                    $display("FAIL ovf_at_full got=%b/%0d exp=0/16", overflow, fifo_count); end
            end
        end
        flag_ciphertext_ready = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", fifo_count); end
        total++; if (char_count !== 16'd16) begin bad++; $display("FAIL ovf_chars got=%0d exp=16", char_count); end
        total++; if (out_char !== 8'h60) begin bad++; $display("FAIL ovf_head got=%h exp=60", out_char); end
    endtask

    // Continues from a full FIFO holding 60..6F.
    task automatic test_full_push_pop();
        logic [7:0] exp_c;
        pulse_clear();
        total++; if (overflow !== 1'b0 || char_count !== 16'd0 || fifo_count !== 5'd16) begin bad++;
            $display("FAIL clear_keeps_fifo got=%b/%0d/%0d exp=0/0/16", overflow, char_count, fifo_count); end
        flag_ciphertext_ready = 1'b1;
        ciphertext_char = 8'h5A;
        out_ready = 1'b1;
        tick();
        flag_ciphertext_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL fpp_count got=%0d exp=16", fifo_count); end
        total++; if (char_count !== 16'd1) begin bad++; $display("FAIL fpp_chars got=%0d exp=1", char_count); end
        for (int i = 0; i < 16; i++) begin
            exp_c = (i == 15) ? 8'h5A : 8'h61 + 8'(i);
            total++; if (out_valid !== 1'b1 || out_char !== exp_c) begin bad++;
                $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_char, exp_c); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin bad++;
            $display("FAIL fpp_empty got=%b/%0d exp=0/0", out_valid, fifo_count); end
    endtask

    task automatic test_error_counts();
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            err_invalid_key_shift_num = 1'b1;
            err_invalid_ptxt_char = (i >= 1 && i <= 3);
            tick();
        end
        err_invalid_key_shift_num = 1'b0;
        err_invalid_ptxt_char = 1'b0;
        tick();
        total++; if (key_err_count !== 16'd5) begin bad++; $display("FAIL key_err got=%0d exp=5", key_err_count); end
        total++; if (ptxt_err_count !== 16'd3) begin bad++; $display("FAIL ptxt_err got=%0d exp=3", ptxt_err_count); end
        total++; if (fifo_count !== 5'd0 || char_count !== 16'd0 || out_valid !== 1'b0) begin bad++;
            $display("FAIL err_fifo got=%0d/%0d/%b exp=0/0/0", fifo_count, char_count, out_valid); end
    endtask

    task automatic test_saturation();
        pulse_clear();
        err_invalid_ptxt_char = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total++; if (s_ptxt_err_count !== 4'd15) begin bad++; $display("FAIL sat_small got=%0d exp=15", s_ptxt_err_count); end
        total++; if (ptxt_err_count !== 16'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", ptxt_err_count); end
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        total++; if (s_ptxt_err_count !== 4'd0) begin bad++; $display("FAIL sat_clear got=%0d exp=0", s_ptxt_err_count); end
        tick();
        total++; if (s_ptxt_err_count !== 4'd1) begin bad++; $display("FAIL sat_after got=%0d exp=1", s_ptxt_err_count); end
        err_invalid_ptxt_char = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        flag_ciphertext_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ciphertext_char = 8'h80 + 8'(i);
            tick();
        end
        flag_ciphertext_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        out_ready = 1'b0;
        total++; if (fifo_count !== 5'd4 || overflow !== 1'b1 || out_char !== 8'h8C) begin bad++;
            $display("FAIL mid_pre got=%0d/%b/%h exp=4/1/8c", fifo_count, overflow, out_char); end
        rst = 1'b1;
        flag_ciphertext_ready = 1'b1;
        ciphertext_char = 8'hEE;
        err_invalid_key_shift_num = 1'b1;
        tick();
        rst = 1'b0;
        err_invalid_key_shift_num = 1'b0;
        ciphertext_char = 8'h77;
        total++; if (fifo_count !== 5'd0 || out_valid !== 1'b0 || out_char !== 8'h00) begin bad++;
            $display("FAIL mid_rst_fifo got=%0d/%b/%h exp=0/0/00", fifo_count, out_valid, out_char); end
        total++; if (overflow !== 1'b0 || char_count !== 16'd0 || key_err_count !== 16'd0 || ptxt_err_count !== 16'd0) begin bad++;
            $display("FAIL mid_rst_stats got=%b/%0d/%0d/%0d exp=0/0/0/0", overflow, char_count, key_err_count, ptxt_err_count); end
        tick();
        flag_ciphertext_ready = 1'b0;
        total++; if (fifo_count !== 5'd1 || out_char !== 8'h77 || char_count !== 16'd1) begin bad++;
            $display("FAIL mid_post got=%0d/%h/%0d exp=1/77/1", fifo_count, out_char, char_count); end
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_basic_stream();
        test_overflow();
        test_full_push_pop();
        test_error_counts();
        test_saturation();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/caesar_ciphertext_collector.md
# caesar_ciphertext_collector

Downstream stage of the three-stage Caesar cipher core. Samples the core's registered outputs every clock, buffers each valid ciphertext character in a first-word-fall-through FIFO, and presents the characters on a valid/ready byte stream to the next consumer (UART/host interface). Keeps saturating statistics on accepted characters and on the core's key and plaintext error flags. Holds a sticky overflow flag for characters dropped because the FIFO was full.

## Interface
- DEPTH, 16: FIFO depth in characters; power of two, ≥ 2.
- CNT_W, 16: width of each statistics counter.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ciphertext_char  in  8  character from the cipher core.
- flag_ciphertext_ready  in  1  core qualifier; high means ciphertext_char is valid this cycle.
- err_invalid_key_shift_num  in  1  core key-error flag; sampled every cycle.
- err_invalid_ptxt_char  in  1  core plaintext-error flag; sampled every cycle.
- clear_stats  in  1  one-cycle pulse; clears counters and overflow.
- out_char  out  8  head-of-FIFO character.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_char when high together with out_valid.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a character was dropped.
- char_count  out  CNT_W  characters written into the FIFO.
- key_err_count  out  CNT_W  cycles with err_invalid_key_shift_num high.
- ptxt_err_count  out  CNT_W  cycles with err_invalid_ptxt_char high.

## Operation
- Storage: DEPTH×8 register array, write pointer and read pointer of $clog2(DEPTH) bits with natural wrap, and an occupancy counter. full = (fifo_count == DEPTH). empty = (fifo_count == 0).
- Push request: flag_ciphertext_ready. Pop: out_valid && out_ready.
- Write enable = push && (!full || pop). If the FIFO is full and a pop happens in the same cycle, the write is accepted and occupancy stays at DEPTH.
- Drop: push && full && !pop. The character is discarded, overflow is set to 1, and the FIFO is unchanged.
- Simultaneous push and pop when not empty: occupancy is unchanged and both pointers advance.
- Push when empty: the character is written and becomes visible on the next cycle. There is no same-cycle bypass.
- out_char = mem[rd_ptr] when out_valid is high; it is forced to 8'h00 when the FIFO is empty.
- char_count increments on each write enable (not on drops).
- key_err_count and ptxt_err_count each increment on every cycle in which the corresponding flag is high. Both may increment in the same cycle.
- All counters saturate at 2^CNT_W−1 and do not wrap.
- clear_stats zeroes the three counters and overflow on the next edge. If a clear and an increment or overflow event occur in the same cycle, the clear wins. clear_stats does not affect FIFO contents or pointers.
- The error flags do not gate pushes. The core already holds flag_ciphertext_ready low on error.

## Timing
- Reset (rst high at an edge): pointers = 0, fifo_count = 0, out_valid = 0, out_char = 8'h00, overflow = 0, and all counters = 0. Reset takes priority over every other input. Reset in the middle of a stream discards all buffered characters.
- Latency: a character sampled at edge N appears on out_char/out_valid after edge N (1 cycle). Core input to collector output is therefore 1 cycle.
- Throughput: 1 character per cycle sustained when out_ready is held high.
- Handshake: out_char and out_valid remain stable while out_valid && !out_ready.
- fifo_count, overflow, and the counters are registered and update on the same edge as the event that changes them.

## Test plan
- Reset, then push 'A'(41),'B'(42),'C'(43) on consecutive cycles with out_ready=0: fifo_count=3, out_char=41, char_count=3. Then raise out_ready: outputs 41,42,43 on consecutive cycles, then out_valid=0 and out_char=00.
- With DEPTH=16 and out_ready=0, push 17 characters: fifo_count=16, overflow=1 after the 17th, char_count=16. Draining returns the first 16 characters in order.
- Full FIFO, push 5A with out_ready=1 in the same cycle: no overflow, fifo_count stays 16, and 5A is the last character drained.
- Hold err_invalid_key_shift_num high for 5 cycles and err_invalid_ptxt_char high for 3 overlapping cycles: key_err_count=5, ptxt_err_count=3, FIFO untouched.
- With CNT_W=4, hold err_invalid_ptxt_char high for 20 cycles: ptxt_err_count saturates at 15. Then pulse clear_stats while the flag is still high: the count reads 0 after that edge and 1 after the next.
- With 4 characters buffered and overflow=1, assert rst for one cycle mid-stream: all outputs return to their reset values. Pushes on the next cycle are accepted normally.
